// File: rtl/nxs_pkg.sv
// Shared types and constants for the SK1024 nonce path.
// Used by the dispatch side, the collector and the benches.
package nxs_pkg;

  localparam int NONCE_W = 64;
  localparam int QWORD_W = 64;

  localparam int SKEIN_BLK_STAGES  = 2;
  localparam int KECCAK_BLK_STAGES = 3;
  localparam int TOTAL_STAGES =
    SKEIN_BLK_STAGES + KECCAK_BLK_STAGES;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } nxs_state_e;

endpackage

// File: rtl/nxs_found_fifo.sv
// Found-nonce FIFO with the head held in a register.
// Shift-down storage: entry 0 is always the head.
module nxs_found_fifo
  import nxs_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nHashRst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    wr_idx;
  logic             do_pop;
  logic             do_push;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[0];

  // Shift on pop, then append at the first free slot.
  always_comb begin
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_idx  = do_pop ? cnt_q - CW'(1) : cnt_q;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++)
        mem_d[i] = mem_q[i+1];
    end
    if (do_push)
      mem_d[wr_idx[AW-1:0]] = din;
    if (do_push && !do_pop)
      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push)
      cnt_d = cnt_q - CW'(1);
  end

  // Storage and fill-level registers.
  always_ff @(posedge clk or negedge nHashRst) begin
    if (!nHashRst) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/nxs_nonce_collector.sv
// SK1024 tail: pairs results with nonces, queues hits.
// RESULT_QWORD_CAPTURE_EN adds found_qword to each entry.
module nxs_nonce_collector
  import nxs_pkg::*;
#(
  parameter int ZERO_BITS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               nHashRst,
  input  logic               start,
  input  logic               stop,
  input  logic [NONCE_W-1:0] base_nonce,
  input  logic               res_valid,
  input  logic [QWORD_W-1:0] res_qword,
  output logic               found_valid,
  input  logic               found_ready,
  output logic [NONCE_W-1:0] found_nonce,
`ifdef RESULT_QWORD_CAPTURE_EN
  output logic [QWORD_W-1:0] found_qword,
`endif
  output logic [63:0]        hash_count,
  output logic               overflow,
  output logic               running
);

`ifdef RESULT_QWORD_CAPTURE_EN
  localparam int FW = QWORD_W + NONCE_W;
`else
  localparam int FW = NONCE_W;
`endif

  nxs_state_e         state_q, state_d;
  logic [NONCE_W-1:0] ctr_q, ctr_d;
  logic [63:0]        cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               s1_hit_q, s1_hit_d;
  logic [NONCE_W-1:0] s1_nonce_q, s1_nonce_d;
  logic [QWORD_W-1:0] s1_qword_q, s1_qword_d;
  logic [FW-1:0]      fifo_din;
  logic [FW-1:0]      fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               fifo_drop;
  logic               hit;
  logic               accept;

  assign hit = (res_qword[QWORD_W-1 -: ZERO_BITS] == '0);
  assign fifo_pop  = found_ready && !fifo_empty;
  assign fifo_drop = s1_hit_q && fifo_full && !fifo_pop;

`ifdef RESULT_QWORD_CAPTURE_EN
  assign fifo_din    = {s1_qword_q, s1_nonce_q};
  assign found_qword = fifo_dout[FW-1 -: QWORD_W];
`else
  assign fifo_din    = s1_nonce_q;
`endif

  assign found_nonce = fifo_dout[NONCE_W-1:0];
  assign found_valid = !fifo_empty;
  assign hash_count  = cnt_q;
  assign overflow    = ovf_q;
  assign running     = (state_q == RUN);

  // Next state, nonce tracking and stage-1 capture.
  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    s1_hit_d   = 1'b0;
    s1_nonce_d = s1_nonce_q;
    s1_qword_d = s1_qword_q;
    accept = (state_q == RUN) && res_valid
             && !start && !stop;
    if (accept) begin
      s1_hit_d   = hit;
      s1_nonce_d = ctr_q;
      s1_qword_d = res_qword;
      ctr_d      = ctr_q + NONCE_W'(1);
      cnt_d      = cnt_q + 64'd1;
    end
    if (start) begin
      state_d = RUN;
      ctr_d   = base_nonce;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
    end
    if (fifo_drop)
      ovf_d = 1'b1;
  end

  // Control and stage-1 registers.
  always_ff @(posedge clk or negedge nHashRst) begin
    if (!nHashRst) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_nonce_q <= '0;
      s1_qword_q <= '0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      s1_hit_q   <= s1_hit_d;
      s1_nonce_q <= s1_nonce_d;
      s1_qword_q <= s1_qword_d;
    end
  end

  nxs_found_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .nHashRst (nHashRst),
    .push     (s1_hit_q),
    .din      (fifo_din),
    .pop      (fifo_pop),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
